// File: rtl/raccoon_h_pkg.sv
// Shared constants, types and state encoding for the h-coefficient word packer.
package raccoon_h_pkg;

    localparam int LANE_W = 7;
    localparam int LANES  = 8;
    localparam int WORD_W = LANE_W * LANES;

    // Saturation limits of one 7-bit two's-complement lane.
    localparam logic signed [LANE_W-1:0] LANE_MAX = 7'sd63;
    localparam logic signed [LANE_W-1:0] LANE_MIN = -7'sd64;

    // Lane k of a packed word lives at bits [7k+6:7k].
    typedef logic [LANES-1:0][LANE_W-1:0] lane_buf_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/h_word_packer_if.sv
// Coefficient input handshake and packed-word output bus of the h word packer.
//
// Handshake: the master holds coeff_in stable while in_valid is high; a
// coefficient is consumed on a rising edge where in_valid and in_ready are
// both high. in_valid while in_ready is low consumes nothing. The output side
// has no back-pressure: Check_h_out is new data exactly when out_flag is high.
interface h_word_packer_if
    import raccoon_h_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int CNT_W = 16
);
    logic                     start;
    logic [CNT_W-1:0]         n_coeffs;
    logic                     in_valid;
    logic                     in_ready;
    logic signed [IN_W-1:0]   coeff_in;
    logic [WORD_W-1:0]        Check_h_out;
    logic                     out_flag;
    logic                     done;
    logic [CNT_W-1:0]         sat_cnt;

    modport master (
        output start, n_coeffs, in_valid, coeff_in,
        input  in_ready, Check_h_out, out_flag, done, sat_cnt
    );

    modport slave (
        input  start, n_coeffs, in_valid, coeff_in,
        output in_ready, Check_h_out, out_flag, done, sat_cnt
    );
endinterface

// File: rtl/h_lane_clamp.sv
// Combinational saturator from a signed IN_W coefficient to one 7-bit lane.
module h_lane_clamp
    import raccoon_h_pkg::*;
#(
    parameter int IN_W = 16
) (
    input  logic signed [IN_W-1:0] i_coeff,
    output logic [LANE_W-1:0]      o_lane,
    output logic                   o_sat
);
    // Lane limits sign-extended to the input width for a signed compare.
    localparam logic signed [IN_W-1:0] C_MAX = IN_W'(LANE_MAX);
    localparam logic signed [IN_W-1:0] C_MIN = IN_W'(LANE_MIN);

    // Clamp to [-64, 63]; in-range values keep their low 7 bits.
    always_comb begin
        o_sat  = 1'b0;
        o_lane = i_coeff[LANE_W-1:0];
        if (i_coeff > C_MAX) begin
            o_lane = LANE_MAX;
            o_sat  = 1'b1;
        end else if (i_coeff < C_MIN) begin
            o_lane = LANE_MIN;
            o_sat  = 1'b1;
        end
    end
endmodule

// File: rtl/h_word_packer.sv
// Packs saturated h coefficients eight to a 56-bit word, one frame at a time.
// The lane buffer fills while the previous word sits in the output register,
// so a completed word never stalls the input.
module h_word_packer
    import raccoon_h_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    h_word_packer_if.slave  bus,
    output state_e          o_dbg_state
);
    state_e            r_state;
    lane_buf_t         r_lanes;
    logic [2:0]        r_lane_idx;
    logic [CNT_W-1:0]  r_remaining;
    logic              r_emit;
    logic [WORD_W-1:0] r_word;
    logic              r_flag;
    logic              r_done;
    logic [CNT_W-1:0]  r_sat_cnt;

    logic [LANE_W-1:0] w_lane;
    logic              w_sat;
    logic              w_xfer;
    lane_buf_t         w_lanes_next;

    h_lane_clamp #(.IN_W(IN_W)) u_clamp (
        .i_coeff (bus.coeff_in),
        .o_lane  (w_lane),
        .o_sat   (w_sat)
    );

    assign w_xfer          = bus.in_valid && (r_state == FILL);
    assign bus.in_ready    = (r_state == FILL);
    assign bus.Check_h_out = r_word;
    assign bus.out_flag    = r_flag;
    assign bus.done        = r_done;
    assign bus.sat_cnt     = r_sat_cnt;
    assign o_dbg_state     = r_state;

    // Next lane buffer: cleared when its word is handed off, then the
    // incoming lane (if any) is written on top.
    always_comb begin
        w_lanes_next = r_emit ? '0 : r_lanes;
        if (w_xfer) begin
            w_lanes_next[r_lane_idx] = w_lane;
        end
    end

    // Frame FSM, lane buffer, counters and registered output strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_lanes     <= '0;
            r_lane_idx  <= '0;
            r_remaining <= '0;
            r_emit      <= 1'b0;
            r_word      <= '0;
            r_flag      <= 1'b0;
            r_done      <= 1'b0;
            r_sat_cnt   <= '0;
        end else begin
            r_flag  <= 1'b0;
            r_done  <= 1'b0;
            r_lanes <= w_lanes_next;

            if (r_emit) begin
                r_word <= r_lanes;
                r_flag <= 1'b1;
                r_emit <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.n_coeffs == '0) begin
                            r_state <= FIN;
                        end else begin
                            r_remaining <= bus.n_coeffs;
                            r_sat_cnt   <= '0;
                            r_lane_idx  <= '0;
                            r_state     <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (w_xfer) begin
                        r_lane_idx  <= r_lane_idx + 3'd1;
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (w_sat && (r_sat_cnt != '1)) begin
                            r_sat_cnt <= r_sat_cnt + CNT_W'(1);
                        end
                        if ((r_lane_idx == 3'd7) || (r_remaining == CNT_W'(1))) begin
                            r_emit <= 1'b1;
                        end
                        if (r_remaining == CNT_W'(1)) begin
                            r_state <= FIN;
                        end
                    end
                end
                FIN: begin
                    // Hold until the last word has been strobed so done trails it.
                    if (!r_emit) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_h_word_packer.sv
// Self-checking bench for h_word_packer: directed frames plus randomized
// frames, compared every cycle against a frame-level queue model.
module tb_h_word_packer;
    import raccoon_h_pkg::*;

    localparam int IN_W  = 16;
    localparam int CNT_W = 16;

    typedef struct {
        int               at;
        logic [WORD_W-1:0] w;
    } ev_t;

    // ---------------- clock / reset ----------------
    logic   clk = 1'b0;
    logic   rst_n;
    state_e dbg_state;

    always #5 clk = ~clk;

    h_word_packer_if #(.IN_W(IN_W), .CNT_W(CNT_W)) bus ();

    h_word_packer #(.IN_W(IN_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int                cyc = 0;
    bit                m_active;
    bit                m_busy;
    int                m_n;
    int                m_consumed;
    int                m_sat;
    int                m_done_edge;
    int                m_v;
    bit                m_idle_now;
    logic [LANE_W-1:0] m_lanes[$];
    logic [WORD_W-1:0] m_word;
    logic [WORD_W-1:0] m_pack;
    ev_t               exp_q[$];
    bit                exp_flag;
    bit                exp_done;

    logic [WORD_W-1:0] got_words[$];
    int                got_done = 0;

    function automatic logic [LANE_W-1:0] clamp7(input int v);
        logic [31:0] b;
        b = v;
        if (v > 63)  return 7'h3F;
        if (v < -64) return 7'h40;
        return b[6:0];
    endfunction

    function automatic bit is_sat(input int v);
        return (v > 63) || (v < -64);
    endfunction

    task automatic model_reset();
        m_active    = 1'b0;
        m_busy      = 1'b0;
        m_n         = 0;
        m_consumed  = 0;
        m_sat       = 0;
        m_done_edge = -10;
        m_word      = '0;
        m_lanes.delete();
        exp_q.delete();
    endtask

    // Advance the model on each edge from the inputs the DUT saw, then
    // compare all outputs just after the edge.
    always @(posedge clk) begin
        cyc++;
        exp_flag = 1'b0;
        exp_done = 1'b0;
        if (!rst_n) begin
            model_reset();
        end else begin
            m_idle_now = !m_busy;
            if (exp_q.size() > 0 && exp_q[0].at == cyc) begin
                m_word = exp_q[0].w;
                void'(exp_q.pop_front());
                exp_flag = 1'b1;
            end
            if (m_done_edge == cyc) begin
                exp_done = 1'b1;
                m_busy   = 1'b0;
            end
            if (m_active && bus.in_valid) begin
                m_v = int'(bus.coeff_in);
                m_lanes.push_back(clamp7(m_v));
                if (is_sat(m_v) && m_sat < 65535) m_sat++;
                m_consumed++;
                if (m_lanes.size() == LANES || m_consumed == m_n) begin
                    m_pack = '0;
                    foreach (m_lanes[i]) m_pack[i*LANE_W +: LANE_W] = m_lanes[i];
                    exp_q.push_back('{at: cyc + 1, w: m_pack});
                    m_lanes.delete();
                end
                if (m_consumed == m_n) begin
                    m_active    = 1'b0;
                    m_done_edge = cyc + 2;
                end
            end else if (m_idle_now && bus.start) begin
                m_busy = 1'b1;
                if (bus.n_coeffs == '0) begin
                    m_done_edge = cyc + 1;
                end else begin
                    m_active   = 1'b1;
                    m_n        = int'(bus.n_coeffs);
                    m_consumed = 0;
                    m_sat      = 0;
                    m_lanes.delete();
                end
            end
        end
        #1;
        check("out_flag", 64'(bus.out_flag), 64'(exp_flag));
        check("done", 64'(bus.done), 64'(exp_done));
        check("in_ready", 64'(bus.in_ready), 64'(m_active));
        check("sat_cnt", 64'(bus.sat_cnt), 64'(m_sat));
        check("Check_h_out", 64'(bus.Check_h_out), 64'(m_word));
        if (bus.out_flag) got_words.push_back(bus.Check_h_out);
        if (bus.done) got_done++;
    end

    // ---------------- driver tasks ----------------
    logic signed [IN_W-1:0] tx_q[$];
    int                     last_w0;

    task automatic start_frame(input int n);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.n_coeffs = CNT_W'(n);
        @(negedge clk);
        bus.start    = 1'b0;
    endtask

    // mode 0: valid every cycle, 1: alternate 1,0,..., 2: random.
    task automatic feed(input int cnt, input int mode, input int mid_start_at);
        int sent;
        int k;
        logic rdy;
        sent = 0;
        k    = 0;
        while (sent < cnt && k < 2000) begin
            case (mode)
                0:       bus.in_valid = 1'b1;
                1:       bus.in_valid = (k % 2 == 0);
                default: bus.in_valid = ($urandom_range(0, 3) != 0);
            endcase
            bus.coeff_in = (tx_q.size() > 0) ? tx_q[0] : '0;
            bus.start    = (k == mid_start_at);
            if (k == mid_start_at) bus.n_coeffs = CNT_W'(3);
            rdy = bus.in_ready;
            @(posedge clk);
            if (bus.in_valid && rdy) begin
                void'(tx_q.pop_front());
                sent++;
            end
            @(negedge clk);
            k++;
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        if (sent < cnt) check("feed_timeout", 64'(sent), 64'(cnt));
    endtask

    task automatic run_frame(input int n, input int mode, input int mid, output int nwords);
        int d0;
        int waitc;
        d0      = got_done;
        last_w0 = got_words.size();
        start_frame(n);
        feed(n, mode, mid);
        waitc = 0;
        while (got_done == d0 && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        @(negedge clk);
        check("done_count", 64'(got_done - d0), 64'd1);
        nwords = got_words.size() - last_w0;
    endtask

    // ---------------- stimulus ----------------
    int                nw;
    int                n;
    int                v;
    logic [WORD_W-1:0] wtmp;
    int                bval[8] = '{63, 64, -64, -65, 32767, -32768, 0, -1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        rst_n        = 1'b1;
        bus.start    = 1'b0;
        bus.n_coeffs = '0;
        bus.in_valid = 1'b0;
        bus.coeff_in = '0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_word", 64'(bus.Check_h_out), 64'd0);

        // 8 coefficients 1..8 back-to-back: one full word.
        for (int i = 1; i <= 8; i++) tx_q.push_back(16'(i));
        run_frame(8, 0, -1, nw);
        check("t1_nwords", 64'(nw), 64'd1);
        wtmp = got_words[last_w0];
        check("t1_word", 64'(wtmp),
              64'({7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1}));
        check("t1_sat", 64'(bus.sat_cnt), 64'd0);

        // in_valid while idle must not consume anything.
        bus.coeff_in = 16'sd5;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;

        // Ten -1 values: full word of 7'h7F then a two-lane word.
        for (int i = 0; i < 10; i++) tx_q.push_back(-16'sd1);
        run_frame(10, 0, -1, nw);
        check("t2_nwords", 64'(nw), 64'd2);
        wtmp = got_words[last_w0];
        check("t2_word0", 64'(wtmp), 64'h00FF_FFFF_FFFF_FFFF);
        wtmp = got_words[last_w0 + 1];
        check("t2_word1", 64'(wtmp), 64'h3FFF);

        // Clamping both ways plus a partial word.
        tx_q.push_back(16'sd100);
        tx_q.push_back(-16'sd200);
        tx_q.push_back(16'sd5);
        run_frame(3, 0, -1, nw);
        check("t3_nwords", 64'(nw), 64'd1);
        wtmp = got_words[last_w0];
        check("t3_word", 64'(wtmp), 64'h1603F);
        check("t3_sat", 64'(bus.sat_cnt), 64'd2);

        // Empty frame: done on the cycle right after the start edge's cycle.
        last_w0 = got_words.size();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.n_coeffs = '0;
        @(negedge clk);
        bus.start = 1'b0;
        check("t4_done_early", 64'(bus.done), 64'd0);
        check("t4_ready", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("t4_done", 64'(bus.done), 64'd1);
        check("t4_ready2", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        check("t4_done_once", 64'(bus.done), 64'd0);
        check("t4_nwords", 64'(got_words.size() - last_w0), 64'd0);
        check("t4_sat_hold", 64'(bus.sat_cnt), 64'd2);

        // Toggling valid across 16 coefficients, with a stray start mid-frame.
        for (int i = 20; i < 36; i++) tx_q.push_back(16'(i));
        run_frame(16, 1, 3, nw);
        check("t5_nwords", 64'(nw), 64'd2);
        wtmp = got_words[last_w0];
        check("t5_word0", 64'(wtmp),
              64'({7'd27, 7'd26, 7'd25, 7'd24, 7'd23, 7'd22, 7'd21, 7'd20}));
        wtmp = got_words[last_w0 + 1];
        check("t5_word1", 64'(wtmp),
              64'({7'd35, 7'd34, 7'd33, 7'd32, 7'd31, 7'd30, 7'd29, 7'd28}));

        // Reset after 5 of 8 saturating coefficients, then a clean frame.
        for (int i = 0; i < 5; i++) tx_q.push_back(16'sd1000);
        start_frame(8);
        feed(5, 0, -1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_ready", 64'(bus.in_ready), 64'd0);
        check("t6_rst_flag", 64'(bus.out_flag), 64'd0);
        check("t6_rst_done", 64'(bus.done), 64'd0);
        check("t6_rst_word", 64'(bus.Check_h_out), 64'd0);
        check("t6_rst_sat", 64'(bus.sat_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete();
        for (int i = 9; i <= 16; i++) tx_q.push_back(16'(i));
        run_frame(8, 0, -1, nw);
        check("t6_nwords", 64'(nw), 64'd1);
        wtmp = got_words[last_w0];
        check("t6_word", 64'(wtmp),
              64'({7'd16, 7'd15, 7'd14, 7'd13, 7'd12, 7'd11, 7'd10, 7'd9}));
        check("t6_sat", 64'(bus.sat_cnt), 64'd0);

        // Randomized frames with boundary-heavy coefficients and random valid.
        for (int f = 0; f < 14; f++) begin
            n = $urandom_range(0, 20);
            tx_q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 2))
                    0:       v = bval[$urandom_range(0, 7)];
                    1:       v = int'($urandom_range(0, 127)) - 64;
                    default: v = int'($urandom_range(0, 65535)) - 32768;
                endcase
                tx_q.push_back(16'(v));
            end
            run_frame(n, 2, (f % 3 == 0) ? 2 : -1, nw);
            check("rnd_nwords", 64'(nw), 64'((n + 7) / 8));
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
